// File: rtl/axis_fifo_pkg.sv
// Shared helpers for axis_fifo: counter/pointer widths and the non-power-of-2 pointer wrap.
package axis_fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Wrap at depth-1 explicitly so any depth works, not only powers of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram_sdp.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_ram_sdp #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_fifo.sv
// AXI-Stream FIFO of any depth with tlast storage, registered level/threshold flags,
// synchronous flush and an optional store-and-forward packet mode.
module axis_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2,
  parameter int PACKET_MODE   = 0
) (
  input  logic                               clk,
  input  logic                               arst,
  input  logic                               flush,
  input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic                               s_axis_tlast,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic                               m_axis_tlast,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic                               almost_full,
  output logic                               almost_empty
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam int LVL_W = cnt_width(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] AFULL_L = LVL_W'(AFULL_THRESH);
  localparam logic [LVL_W-1:0] AEMPTY_L = LVL_W'(AEMPTY_THRESH);

  typedef struct packed {
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
  } word_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d, pkt_cnt_q, pkt_cnt_d;
  logic             cut_q, cut_d;
  logic             tready_q, tready_d;
  logic             afull_q, afull_d, aempty_q, aempty_d;
  logic             push, pop, push_last, pop_last, valid_raw;
  word_t            wr_word, rd_word;

  // Valid/ready: a beat transfers on a rising edge where both valid and ready are high.
  // tready is registered from the next level and never looks at m_axis_tready.
  // Flush forces both handshake outputs low so nothing transfers in a flush cycle.
  assign s_axis_tready = tready_q & ~flush;
  assign valid_raw     = (level_q != '0) &
                         ((PACKET_MODE == 0) || (pkt_cnt_q != '0) || cut_q);
  assign m_axis_tvalid = valid_raw & ~flush;

  assign push      = s_axis_tvalid & s_axis_tready;
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign push_last = push & s_axis_tlast;
  assign pop_last  = pop & rd_word.tlast;

  assign wr_word.tlast = s_axis_tlast;
  assign wr_word.tdata = s_axis_tdata;
  assign m_axis_tdata  = rd_word.tdata;
  assign m_axis_tlast  = rd_word.tlast;

  assign level        = level_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

  fifo_ram_sdp #(
    .WIDTH  (DATA_WIDTH + 1),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_word),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_word)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pkt_cnt_d = pkt_cnt_q;
    cut_d     = cut_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      pkt_cnt_d = '0;
      cut_d     = 1'b0;
    end else begin
      if (push) wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), FIFO_DEPTH));
      if (pop)  rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), FIFO_DEPTH));
      if (push && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
      if (push_last && !pop_last)      pkt_cnt_d = pkt_cnt_q + LVL_W'(1);
      else if (pop_last && !push_last) pkt_cnt_d = pkt_cnt_q - LVL_W'(1);
      // Full with no complete packet would deadlock: release it as a cut-through packet.
      if (pop_last)                                      cut_d = 1'b0;
      else if (level_q == DEPTH_L && pkt_cnt_q == '0)    cut_d = 1'b1;
    end
    tready_d = (level_d < DEPTH_L);
    afull_d  = (level_d >= AFULL_L);
    aempty_d = (level_d <= AEMPTY_L);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkt_cnt_q <= '0;
      cut_q     <= 1'b0;
      tready_q  <= 1'b0;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pkt_cnt_q <= pkt_cnt_d;
      cut_q     <= cut_d;
      tready_q  <= tready_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (arst)
    !(push && !pop && level_q == DEPTH_L));
  no_underflow: assert property (@(posedge clk) disable iff (arst)
    !(pop && level_q == '0));

endmodule
